// File: rtl/line_write_buffer.sv
// Single-entry write-back buffer: holds a dirty line, coalesces same-line
// writes, forwards to miss reads and drains to pmem when pmem is idle.
module line_write_buffer #(
  parameter int HOLD_CYCLES = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [LINE_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [LINE_WIDTH-1:0] fwd_data,
  input  logic                  pmem_busy,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  output logic                  empty
);

  localparam int TW = ADDR_WIDTH - 4;
  localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pwrite_q, pwrite_d;

  logic [TW-1:0] wb_tag;
  logic          tag_match;
  logic          xfer;
  logic          unused_lsb;

  assign wb_tag     = wb_addr[ADDR_WIDTH-1:4];
  assign tag_match  = (wb_tag == tag_q);
  assign xfer       = wb_valid && wb_ready;
  assign unused_lsb = ^{wb_addr[3:0], fwd_addr[3:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      tag_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    unique case (state_q)
      EMPTY: begin
        if (xfer) begin
          tag_d   = wb_tag;
          data_d  = wb_data;
          cnt_d   = '0;
          state_d = HELD;
        end
      end
      HELD: begin
        if (xfer) begin
          data_d = wb_data;
          cnt_d  = '0;
        end else begin
          if (cnt_q != CMAX) cnt_d = cnt_q + CW'(1);
          // a pending wb_valid here is a conflicting line: drain to make room
          if (!pmem_busy && (cnt_q == CMAX || wb_valid)) begin
            state_d  = DRAIN;
            pwrite_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          state_d  = EMPTY;
          pwrite_d = 1'b0;
        end
      end
      default: begin
        state_d  = EMPTY;
        pwrite_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wb_ready     = 1'b0;
    empty        = (state_q == EMPTY);
    fwd_hit      = (state_q != EMPTY) &&
                   (fwd_addr[ADDR_WIDTH-1:4] == tag_q);
    fwd_data     = data_q;
    pmem_write   = pwrite_q;
    pmem_address = {tag_q, 4'b0};
    pmem_wdata   = data_q;
    unique case (state_q)
      EMPTY:   wb_ready = 1'b1;
      HELD:    wb_ready = tag_match;
      DRAIN:   wb_ready = 1'b0;
      default: wb_ready = 1'b0;
    endcase
  end

endmodule
